wb_axi_drain: RTL and testbench

WB_AXI_DRAIN -- requirements
Module: wb_axi_drain

---
 rtl/wb_axi_drain_if.sv | 52 +++++
 rtl/wb_axi_drain.sv | 122 ++++++++++++
 tb/tb_wb_axi_drain.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_axi_drain_if.sv
// Bundle of signals between the write-buffer drain and its two neighbours:
// the entry queue and the AXI3 write channels, plus the busy/bus_err status.
interface wb_axi_drain_if #(
    parameter int DATA_WEDTH = 71
);
    // Queue side
    logic                  is_empty;
    logic [DATA_WEDTH-1:0] rdata_pack;
    logic                  complete;

    // AXI3 write address
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    // AXI3 write data
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    // AXI3 write response
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // Status
    logic        busy;
    logic        bus_err;

    modport master (
        input  is_empty, rdata_pack, awready, wready, bid, bresp, bvalid,
        output complete, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awvalid, wid, wdata, wstrb, wlast, wvalid, bready, busy, bus_err
    );

    modport slave (
        output is_empty, rdata_pack, awready, wready, bid, bresp, bvalid,
        input  complete, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awvalid, wid, wdata, wstrb, wlast, wvalid, bready, busy, bus_err
    );
endinterface

// File: rtl/wb_axi_drain.sv
// Drains a write-buffer queue one entry at a time as single-beat AXI3 writes,
// popping each entry only after its write response has been accepted.
module wb_axi_drain #(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         DATA_WEDTH = 71
) (
    input  logic           clk,
    input  logic           resetn,
    wb_axi_drain_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic [DATA_WEDTH-1:0] entry_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  bready_q;
    logic                  complete_q;
    logic                  bus_err_q;

    logic aw_hs;
    logic w_hs;
    logic aw_done_d;
    logic w_done_d;

    assign aw_hs     = awvalid_q & bus.awready;
    assign w_hs      = wvalid_q & bus.wready;
    // Done flags including this cycle's handshake, so SEND can exit on it
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            entry_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bready_q   <= 1'b0;
            complete_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.is_empty) begin
                        entry_q   <= bus.rdata_pack;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // Error responses are recorded but the entry is still retired
                    if (bus.bvalid) begin
                        bready_q   <= 1'b0;
                        complete_q <= 1'b1;
                        if (bus.bresp != 2'b00) begin
                            bus_err_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.awid     = AXI_ID;
    assign bus.awaddr   = entry_q[63:32];
    assign bus.awlen    = 8'd0;
    assign bus.awsize   = entry_q[70:68];
    assign bus.awburst  = 2'b01;
    assign bus.awlock   = 2'b00;
    assign bus.awcache  = 4'b0000;
    assign bus.awprot   = 3'b000;
    assign bus.awvalid  = awvalid_q;

    assign bus.wid      = AXI_ID;
    assign bus.wdata    = entry_q[31:0];
    assign bus.wstrb    = entry_q[67:64];
    assign bus.wlast    = 1'b1;
    assign bus.wvalid   = wvalid_q;

    assign bus.bready   = bready_q;
    assign bus.complete = complete_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.bus_err  = bus_err_q;

    // The response ID is deliberately ignored: only one write is ever in flight
    logic unused_bid;
    assign unused_bid = ^bus.bid;
endmodule

// File: tb/tb_wb_axi_drain.sv
// Directed bench for wb_axi_drain: a small queue model feeds entries and each
// step compares the AXI/queue outputs against hand-computed values.
module tb_wb_axi_drain;
    logic clk;
    logic resetn;

    wb_axi_drain_if #(.DATA_WEDTH(71)) bus();

    wb_axi_drain #(.AXI_ID(4'd1), .DATA_WEDTH(71)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue model: tail advanced by the stimulus, head popped on complete
    logic [70:0] q_mem [16];
    int          q_head = 0;
    int          q_tail = 0;
    logic        corrupt = 1'b0;

    assign bus.is_empty   = (q_head == q_tail);
    assign bus.rdata_pack = corrupt ? 71'd0 : q_mem[q_head[3:0]];

    always @(posedge clk) begin
        if (bus.complete) q_head <= q_head + 1;
    end

    // Event monitor
    int          n_complete = 0;
    logic [31:0] aw_log [$];

    always @(posedge clk) begin
        if (bus.complete) n_complete++;
        if (bus.awvalid && bus.awready) aw_log.push_back(bus.awaddr);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] size);
        q_mem[q_tail[3:0]] = {size, strb, addr, data};
        q_tail = q_tail + 1;
    endtask

    task automatic wait_bready(input string tag);
        for (int k = 0; k < 50 && !bus.bready; k++) tick();
        check(tag, bus.bready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c0;
    int a0;

    initial begin
        resetn      = 1'b0;
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.bid     = 4'd1;
        #1;
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_complete", bus.complete, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_bus_err", bus.bus_err, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        // Single entry, everything ready
        bus.bvalid = 1'b1;
        push(32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF, 3'd2);
        $display("txn1: single entry addr=1fc00010");
        tick();
        check("t1_awvalid", bus.awvalid, 1);
        check("t1_wvalid", bus.wvalid, 1);
        check("t1_awaddr", bus.awaddr, 32'h1FC0_0010);
        check("t1_wdata", bus.wdata, 32'hDEAD_BEEF);
        check("t1_wstrb", bus.wstrb, 4'hF);
        check("t1_awsize", bus.awsize, 3'd2);
        check("t1_consts", {bus.awlen, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.wlast},
              {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
        check("t1_ids", {bus.awid, bus.wid}, 8'h11);
        check("t1_busy", bus.busy, 1);
        tick();
        check("t1_valids_drop", {bus.awvalid, bus.wvalid}, 2'b00);
        check("t1_bready", bus.bready, 1);
        check("t1_no_complete", bus.complete, 0);
        tick();
        check("t1_complete", bus.complete, 1);
        check("t1_bready_low", bus.bready, 0);
        tick();
        check("t1_complete_once", bus.complete, 0);
        check("t1_idle", bus.busy, 0);
        check("t1_popped", q_head, 1);
        check("t1_bus_err", bus.bus_err, 0);

        // AW held off for three cycles, W goes first
        bus.awready = 1'b0;
        push(32'h0000_2000, 32'h1234_5678, 4'h3, 3'd1);
        $display("txn2: awready delayed 3 cycles");
        tick();
        check("t2_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        tick();
        check("t2_wvalid_drop", bus.wvalid, 0);
        check("t2_awvalid_hold", bus.awvalid, 1);
        tick();
        check("t2_awaddr_stable", bus.awaddr, 32'h0000_2000);
        check("t2_no_bready", bus.bready, 0);
        tick();
        check("t2_awvalid_hold2", bus.awvalid, 1);
        check("t2_wvalid_low", bus.wvalid, 0);
        bus.awready = 1'b1;
        tick();
        check("t2_resp", bus.bready, 1);
        check("t2_awvalid_drop", bus.awvalid, 0);
        tick();
        check("t2_complete", bus.complete, 1);
        tick();
        check("t2_idle", bus.busy, 0);

        // Three entries, B delayed 5 cycles each, error on the second
        bus.bvalid = 1'b0;
        c0 = n_complete;
        a0 = aw_log.size();
        push(32'h0000_3000, 32'hAAAA_0000, 4'hF, 3'd2);
        push(32'h0000_3004, 32'hAAAA_0001, 4'hF, 3'd2);
        push(32'h0000_3008, 32'hAAAA_0002, 4'hF, 3'd2);
        for (int i = 0; i < 3; i++) begin
            $display("txn3.%0d: delayed B, bresp=%0d", i, (i == 1) ? 2 : 0);
            wait_bready("t3_bready");
            for (int d = 0; d < 5; d++) begin
                tick();
                check("t3_wait_no_complete", {bus.complete, bus.bready}, 2'b01);
            end
            bus.bresp  = (i == 1) ? 2'b10 : 2'b00;
            bus.bvalid = 1'b1;
            tick();
            bus.bvalid = 1'b0;
            bus.bresp  = 2'b00;
            check("t3_complete", bus.complete, 1);
            check("t3_bus_err", bus.bus_err, (i == 0) ? 1'b0 : 1'b1);
            tick();
            check("t3_complete_once", bus.complete, 0);
        end
        check("t3_n_complete", n_complete - c0, 3);
        check("t3_n_aw", aw_log.size() - a0, 3);
        if (aw_log.size() - a0 == 3) begin
            check("t3_order0", aw_log[a0], 32'h0000_3000);
            check("t3_order1", aw_log[a0 + 1], 32'h0000_3004);
            check("t3_order2", aw_log[a0 + 2], 32'h0000_3008);
        end
        check("t3_all_popped", q_head, q_tail);
        tick();
        check("t3_bus_err_sticky", bus.bus_err, 1);

        // Queue head overwritten while the entry is in SEND
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        push(32'h0000_4000, 32'hCAFE_F00D, 4'hC, 3'd2);
        $display("txn4: rdata_pack cleared during SEND");
        tick();
        check("t4_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        corrupt = 1'b1;
        tick();
        check("t4_awaddr", bus.awaddr, 32'h0000_4000);
        check("t4_wdata", bus.wdata, 32'hCAFE_F00D);
        tick();
        check("t4_wstrb", bus.wstrb, 4'hC);
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        tick();
        check("t4_resp", bus.bready, 1);
        corrupt    = 1'b0;
        bus.bvalid = 1'b1;
        tick();
        check("t4_complete", bus.complete, 1);
        tick();
        check("t4_idle", bus.busy, 0);

        // Reset while waiting in RESP
        bus.bvalid = 1'b0;
        c0 = n_complete;
        push(32'h0000_5000, 32'h5555_AAAA, 4'hF, 3'd2);
        $display("txn5: reset during RESP");
        tick();
        tick();
        check("t5_in_resp", bus.bready, 1);
        resetn = 1'b0;
        #1;
        check("t5_rst_outputs", {bus.awvalid, bus.wvalid, bus.bready, bus.complete}, 4'b0000);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_bus_err", bus.bus_err, 0);
        tick();
        check("t5_no_complete", n_complete - c0, 0);
        resetn = 1'b1;
        check("t5_release_idle", bus.awvalid, 0);
        bus.bvalid = 1'b1;
        tick();
        check("t5_reissue", {bus.awvalid, bus.wvalid}, 2'b11);
        check("t5_reissue_addr", bus.awaddr, 32'h0000_5000);
        tick();
        check("t5_resp", bus.bready, 1);
        tick();
        check("t5_complete", bus.complete, 1);
        tick();
        check("t5_one_complete", n_complete - c0, 1);
        check("t5_popped", q_head, q_tail);
        check("t5_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
